// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the SRAM arbiter: default bus widths and the
// access state encoding.
package gpu_mem_pkg;

  localparam int GPU_ADDR_W = 18;
  localparam int GPU_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_ZRD  = 3'd3,
    ST_ZWR  = 3'd4
  } state_e;

  function automatic logic st_is_write(state_e s);
    return (s == ST_WR) || (s == ST_ZWR);
  endfunction

  function automatic logic st_is_read(state_e s);
    return (s == ST_RD) || (s == ST_ZRD);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector over N requesters; the pointer names the requester
// searched first and moves just past the winner when adv_i is set.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   idx;
  logic [PW-1:0] sel;
  logic          found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    sel   = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(i);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      sel = idx[PW-1:0];
      if (!found && req_i[sel]) begin
        found      = 1'b1;
        gnt_o[sel] = 1'b1;
        ptr_d      = (sel == PW'(N-1)) ? '0 : sel + 1'b1;
      end
    end
    if (!adv_i) ptr_d = ptr_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Multi-port arbiter for a single asynchronous SRAM: port 0 (display refresh)
// has absolute priority, the rest share round-robin; supports depth-tested writes.
module sram_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_W    = GPU_ADDR_W,
  parameter int DATA_W    = GPU_DATA_W,
  parameter int NUM_PORTS = 3
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic [NUM_PORTS-1:0]          iREQ,
  input  logic [NUM_PORTS-1:0]          iWE,
  input  logic [NUM_PORTS-1:0]          iZTEST,
  input  logic [NUM_PORTS*ADDR_W-1:0]   iADDR,
  input  logic [NUM_PORTS*DATA_W-1:0]   iDATA,
  output logic [NUM_PORTS-1:0]          oACK,
  output logic [NUM_PORTS-1:0]          oRVALID,
  output logic [DATA_W-1:0]             oRDATA,
  output logic                          oZPASS,
  inout  wire  [DATA_W-1:0]             SRAM_DQ,
  output logic [ADDR_W-1:0]             SRAM_ADDR,
  output logic                          SRAM_WE_N,
  output logic                          SRAM_OE_N,
  output logic                          SRAM_CE_N,
  output logic                          SRAM_UB_N,
  output logic                          SRAM_LB_N
);

  state_e                 state_q, state_d;
  logic [NUM_PORTS-1:0]   gnt, g_q;
  logic [NUM_PORTS-1:0]   ack_q, ack_d, rvalid_q, rvalid_d;
  logic [NUM_PORTS-2:0]   rr_gnt;
  logic                   rr_adv, zpass_q, zpass_d, load;
  logic [ADDR_W-1:0]      addr_q, sel_addr;
  logic [DATA_W-1:0]      data_q, sel_data, rdata_q, rdata_d;
  logic                   sel_we, sel_zt;

  rr_arbiter #(.N(NUM_PORTS-1)) u_rr (
    .clk_i (iCLK),
    .rst_i (iRST),
    .req_i (iREQ[NUM_PORTS-1:1]),
    .adv_i (rr_adv),
    .gnt_o (rr_gnt)
  );

  // Port 0 preempts the round-robin, and then must not disturb its pointer.
  assign gnt    = iREQ[0] ? NUM_PORTS'(1) : {rr_gnt, 1'b0};
  assign rr_adv = (state_q == ST_IDLE) && !iREQ[0];

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_we   = 1'b0;
    sel_zt   = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt[p]) begin
        sel_addr = iADDR[p*ADDR_W +: ADDR_W];
        sel_data = iDATA[p*DATA_W +: DATA_W];
        sel_we   = iWE[p];
        sel_zt   = iZTEST[p];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ack_d    = '0;
    rvalid_d = '0;
    zpass_d  = 1'b0;
    rdata_d  = rdata_q;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|iREQ) begin
          load  = 1'b1;
          ack_d = gnt;
          if (!sel_we)      state_d = ST_RD;
          else if (!sel_zt) state_d = ST_WR;
          else              state_d = ST_ZRD;
        end
      end
      ST_RD: begin
        rdata_d  = SRAM_DQ;
        rvalid_d = g_q;
        state_d  = ST_IDLE;
      end
      ST_WR:   state_d = ST_IDLE;
      // Strictly closer wins; equal depth keeps the stored pixel.
      ST_ZRD:  state_d = (data_q < SRAM_DQ) ? ST_ZWR : ST_IDLE;
      ST_ZWR: begin
        zpass_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= ST_IDLE;
      ack_q    <= '0;
      rvalid_q <= '0;
      zpass_q  <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      g_q      <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      zpass_q  <= zpass_d;
      rdata_q  <= rdata_d;
      if (load) begin
        addr_q <= sel_addr;
        data_q <= sel_data;
        g_q    <= gnt;
      end
    end
  end

  // Write and read enables derive from the same state, so they are exclusive.
  assign SRAM_WE_N = !st_is_write(state_q);
  assign SRAM_OE_N = !st_is_read(state_q);
  assign SRAM_DQ   = st_is_write(state_q) ? data_q : {DATA_W{1'bz}};
  assign SRAM_ADDR = addr_q;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign oACK    = ack_q;
  assign oRVALID = rvalid_q;
  assign oRDATA  = rdata_q;
  assign oZPASS  = zpass_q;

endmodule
